// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns byte/half/word requests into word-aligned RAM reads and read-modify-write stores.
// 1-4 RAM cycles plus one DONE (or FAULT) cycle; busy is high throughout and requests are ignored until IDLE.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] ram_address,
  output logic        ram_is_store,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE, S_FAULT
  } state_t;

  state_t      r_state;
  logic        r_is_store;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic        r_busy;
  logic        r_done;
  logic        r_fault;
  logic        r_ram_is_store;
  logic [31:0] r_rdata;
  logic [31:0] r_ram_address;
  logic [31:0] r_ram_wdata;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

  // Decode of the request offered in IDLE
  logic        w_in_misaligned;
  logic        w_in_fault;
  logic        w_in_store_word;
  logic [31:0] w_in_w0;

  assign w_in_misaligned = (req_size == 2'd1 && req_addr[0]) ||
                           (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign w_in_fault      = (req_size == 2'd3) || (ALLOW_MISALIGNED == 0 && w_in_misaligned);
  assign w_in_store_word = req_is_store && req_size == 2'd2 && req_addr[1:0] == 2'd0;
  assign w_in_w0         = {req_addr[31:2], 2'b00};

  // Decode of the latched request
  logic [1:0]  w_off;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [7:0]  w_mask;
  logic        w_spans;
  logic [63:0] w_wshift;
  logic [31:0] w_merge0;
  logic [31:0] w_merge1;
  logic [31:0] w_lo;
  logic [31:0] w_hi;
  logic [31:0] w_ld_raw;
  logic [31:0] w_ld_ext;

  assign w_off    = r_addr[1:0];
  assign w_w0     = {r_addr[31:2], 2'b00};
  assign w_w1     = w_w0 + 32'd4;
  assign w_mask   = size_mask(r_size) << w_off;
  assign w_spans  = |w_mask[7:4];
  assign w_wshift = {32'b0, r_wdata} << {w_off, 3'b000};
  assign w_merge0 = merge(ram_rdata, w_wshift[31:0], w_mask[3:0]);
  assign w_merge1 = merge(ram_rdata, w_wshift[63:32], w_mask[7:4]);

  // In RD1 the low word was captured during RD0 and the live read is the high word
  assign w_lo     = (r_state == S_RD1) ? r_word0 : ram_rdata;
  assign w_hi     = (r_state == S_RD1) ? ram_rdata : 32'd0;
  assign w_ld_raw = 32'({w_hi, w_lo} >> {w_off, 3'b000});

  always_comb begin
    w_ld_ext = w_ld_raw;
    case (r_size)
      2'd0:    w_ld_ext = {{24{r_signed & w_ld_raw[7]}}, w_ld_raw[7:0]};
      2'd1:    w_ld_ext = {{16{r_signed & w_ld_raw[15]}}, w_ld_raw[15:0]};
      default: w_ld_ext = w_ld_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_is_store     <= 1'b0;
      r_signed       <= 1'b0;
      r_size         <= 2'd0;
      r_addr         <= 32'd0;
      r_wdata        <= 32'd0;
      r_word0        <= 32'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fault        <= 1'b0;
      r_ram_is_store <= 1'b0;
      r_rdata        <= 32'd0;
      r_ram_address  <= 32'd0;
      r_ram_wdata    <= 32'd0;
    end else begin
      r_done         <= 1'b0;
      r_fault        <= 1'b0;
      r_ram_is_store <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_is_store <= req_is_store;
            r_signed   <= req_signed;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_busy     <= 1'b1;
            if (w_in_fault) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else if (w_in_store_word) begin
              r_state        <= S_WR0;
              r_ram_address  <= w_in_w0;
              r_ram_is_store <= 1'b1;
              r_ram_wdata    <= req_wdata;
            end else begin
              r_state       <= S_RD0;
              r_ram_address <= w_in_w0;
            end
          end
        end
        S_RD0: begin
          if (r_is_store) begin
            r_state        <= S_WR0;
            r_ram_is_store <= 1'b1;
            r_ram_wdata    <= w_merge0;
          end else if (w_spans) begin
            r_state       <= S_RD1;
            r_word0       <= ram_rdata;
            r_ram_address <= w_w1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_ld_ext;
          end
        end
        S_RD1: begin
          if (r_is_store) begin
            r_state        <= S_WR1;
            r_ram_is_store <= 1'b1;
            r_ram_wdata    <= w_merge1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_ld_ext;
          end
        end
        S_WR0: begin
          if (w_spans) begin
            r_state       <= S_RD1;
            r_ram_address <= w_w1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_WR1: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign fault        = r_fault;
  assign rdata        = r_rdata;
  assign ram_address  = r_ram_address;
  assign ram_is_store = r_ram_is_store;
  assign ram_wdata    = r_ram_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-addressed memory model; a second
// instance with misalignment disallowed covers the fault path.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_is_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, fault, ram_is_store;
  logic [31:0] rdata, ram_address, ram_wdata, ram_rdata;

  logic        n_req_valid, n_req_is_store, n_req_signed;
  logic [1:0]  n_req_size;
  logic [31:0] n_req_addr, n_req_wdata;
  logic        n_busy, n_done, n_fault, n_ram_is_store;
  logic [31:0] n_rdata, n_ram_address, n_ram_wdata, n_ram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // RAM seen by the main instance: decodes address bits [11:2] only
  logic [31:0] ram [0:1023];
  logic        pk_en;
  logic [9:0]  pk_idx;
  logic [31:0] pk_dat;
  assign ram_rdata   = ram[ram_address[11:2]];
  assign n_ram_rdata = 32'h11223344;

  always @(posedge clk) begin
    if (ram_is_store) ram[ram_address[11:2]] <= ram_wdata;
    if (pk_en) ram[pk_idx] <= pk_dat;
  end

  // Reference memory, accessed byte-by-byte
  logic [31:0] mdl [0:1023];
  logic [31:0] mdl_rdata;

  mem_access_unit #(.ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata), .ram_address(ram_address),
    .ram_is_store(ram_is_store), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(0)) dut_na (
    .clk(clk), .rst(rst), .req_valid(n_req_valid), .req_is_store(n_req_is_store),
    .req_size(n_req_size), .req_signed(n_req_signed), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .busy(n_busy), .done(n_done), .fault(n_fault), .rdata(n_rdata), .ram_address(n_ram_address),
    .ram_is_store(n_ram_is_store), .ram_wdata(n_ram_wdata), .ram_rdata(n_ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mget(input logic [31:0] a);
    logic [31:0] w;
    w = mdl[a[11:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic mset(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = mdl[a[11:2]];
    w[{a[1:0], 3'b000} +: 8] = b;
    mdl[a[11:2]] = w;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pk_en = 1'b1; pk_idx = a[11:2]; pk_dat = v;
    mdl[a[11:2]] = v;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int          nb, ncyc, k;
    logic [31:0] w0, w1, exp_rd;
    logic        spans, flt, seen;
    logic [31:0] ea[$];
    logic        es[$];
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    flt   = (sz == 2'd3);
    w0    = a & ~32'd3;
    w1    = w0 + 32'd4;
    spans = (int'(a[1:0]) + nb) > 4;
    if (!flt) begin
      if (st && sz == 2'd2 && a[1:0] == 2'd0) begin
        ea.push_back(w0); es.push_back(1'b1);
      end else begin
        ea.push_back(w0); es.push_back(1'b0);
        if (st) begin ea.push_back(w0); es.push_back(1'b1); end
        if (spans) begin
          ea.push_back(w1); es.push_back(1'b0);
          if (st) begin ea.push_back(w1); es.push_back(1'b1); end
        end
      end
    end
    exp_rd = mdl_rdata;
    if (!flt && !st) begin
      exp_rd = 32'd0;
      for (int i = 0; i < nb; i++) exp_rd |= 32'(mget(a + 32'(i))) << (8 * i);
      if (sg && nb < 4 && exp_rd[8*nb-1]) exp_rd |= 32'hFFFFFFFF << (8 * nb);
    end
    if (!flt && st) for (int i = 0; i < nb; i++) mset(a + 32'(i), wd[8*i +: 8]);

    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Junk requests while busy must have no effect
    req_is_store = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    ncyc = 0; k = 0; seen = 1'b0;
    while (!seen && ncyc < 8) begin
      @(negedge clk);
      ncyc++;
      chk("busy_in_flight", busy, 1);
      if (done || fault) begin
        seen = 1'b1;
        req_valid = 1'b0;
      end else if (k < ea.size()) begin
        chk("ram_address", ram_address, ea[k]);
        chk("ram_is_store", ram_is_store, es[k]);
        k++;
      end
    end
    req_valid = 1'b0;
    if (!seen) chk("timeout_no_done", 0, 1);
    chk("seq_cycles", ncyc, flt ? 1 : ea.size() + 1);
    chk("done", done, !flt);
    chk("fault", fault, flt);
    chk("ram_is_store_final", ram_is_store, 0);
    chk("rdata", rdata, exp_rd);
    mdl_rdata = exp_rd;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("fault_pulse", fault, 0);
    if (!flt && st) begin
      chk("ram_word0", ram[w0[11:2]], mdl[w0[11:2]]);
      chk("ram_word1", ram[w1[11:2]], mdl[w1[11:2]]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_ram_address"}, ram_address, 0);
    chk({tag, "_ram_is_store"}, ram_is_store, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
  endtask

  // Reset lands on the WR0 edge of a spanning word store: word0 commits, word1 must not
  task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w0, w1;
    w0 = a & ~32'd3;
    w1 = w0 + 32'd4;
    for (int i = 0; i < 4; i++)
      if (((a + 32'(i)) & ~32'd3) == w0) mset(a + 32'(i), wd[8*i +: 8]);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd0_addr", ram_address, w0);
    @(negedge clk);
    chk("rst_mid_wr0_store", ram_is_store, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_rdata = 32'd0;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    chk("rst_mid_idle", busy, 0);
    chk("rst_mid_word0", ram[w0[11:2]], mdl[w0[11:2]]);
    chk("rst_mid_word1", ram[w1[11:2]], mdl[w1[11:2]]);
  endtask

  task automatic na_req(input logic st, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic exp_flt, input logic [31:0] exp_rd);
    int   ncyc;
    logic seen, wr;
    @(negedge clk);
    n_req_valid = 1'b1; n_req_is_store = st; n_req_size = sz; n_req_signed = sg;
    n_req_addr = a; n_req_wdata = $urandom;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    ncyc = 0; seen = 1'b0; wr = 1'b0;
    while (!seen && ncyc < 8) begin
      @(negedge clk);
      ncyc++;
      if (n_ram_is_store) wr = 1'b1;
      if (n_done || n_fault) seen = 1'b1;
    end
    chk("na_fault", n_fault, exp_flt);
    chk("na_done", n_done, !exp_flt);
    if (exp_flt) begin
      chk("na_fault_cycles", ncyc, 1);
      chk("na_fault_busy", n_busy, 1);
      chk("na_fault_no_write", wr, 0);
    end else begin
      chk("na_rdata", n_rdata, exp_rd);
    end
    @(negedge clk);
    chk("na_idle", n_busy, 0);
    chk("na_fault_cleared", n_fault, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    n_req_valid = 1'b0; n_req_is_store = 1'b0; n_req_size = 2'd0; n_req_signed = 1'b0;
    n_req_addr = 32'd0; n_req_wdata = 32'd0;
    pk_en = 1'b0; pk_idx = 10'd0; pk_dat = 32'd0;
    mdl_rdata = 32'd0;
    for (int i = 0; i < 1024; i++) poke(32'(i) << 2, $urandom);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    poke(32'h100, 32'h8899AABB);
    do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'd0);
    chk("tp_lb_signed", rdata, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'd0);
    chk("tp_lb_unsigned", rdata, 32'h000000AA);
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF);
    chk("tp_sw_aligned", ram[32'h200 >> 2], 32'hDEADBEEF);
    poke(32'h300, 32'h11223344);
    do_req(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000ABCD);
    chk("tp_sh_merge", ram[32'h300 >> 2], 32'hABCD3344);
    poke(32'h400, 32'h44332211);
    poke(32'h404, 32'h88776655);
    do_req(1'b0, 2'd2, 1'b1, 32'h403, 32'd0);
    chk("tp_lw_span", rdata, 32'h77665544);
    do_req(1'b1, 2'd2, 1'b0, 32'h403, 32'hA1B2C3D4);
    chk("tp_sw_span_w0", ram[32'h400 >> 2], 32'hD4332211);
    chk("tp_sw_span_w1", ram[32'h404 >> 2], 32'h88A1B2C3);
    do_req(1'b0, 2'd3, 1'b0, 32'h400, 32'd0);
    do_req(1'b1, 2'd3, 1'b0, 32'h404, 32'h12345678);
    chk("tp_illegal_no_write", ram[32'h404 >> 2], 32'h88A1B2C3);
    do_req(1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h5A5AA5A5);

    poke(32'h600, 32'h01020304);
    poke(32'h604, 32'h05060708);
    reset_mid_store(32'h602, 32'hCAFEF00D);
    chk("tp_rst_w0", ram[32'h600 >> 2], 32'hF00D0304);
    chk("tp_rst_w1", ram[32'h604 >> 2], 32'h05060708);

    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 4095));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    na_req(1'b0, 2'd1, 1'b0, 32'h501, 1'b1, 32'd0);
    na_req(1'b0, 2'd2, 1'b0, 32'h502, 1'b1, 32'd0);
    na_req(1'b1, 2'd1, 1'b0, 32'h503, 1'b1, 32'd0);
    na_req(1'b1, 2'd2, 1'b0, 32'h501, 1'b1, 32'd0);
    na_req(1'b0, 2'd3, 1'b0, 32'h500, 1'b1, 32'd0);
    na_req(1'b0, 2'd1, 1'b1, 32'h502, 1'b0, 32'h00001122);
    na_req(1'b0, 2'd0, 1'b1, 32'h500, 1'b0, 32'h00000044);
    na_req(1'b0, 2'd2, 1'b0, 32'h504, 1'b0, 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
